// File: rtl/writeback_unit_if.sv
// Write-back stage bundle: upstream instruction handshake, load-data return and
// register-file write port with hazard visibility.
interface writeback_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lsb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        w_en;
  logic [4:0]  rd;
  logic [31:0] w_data;
  logic        wb_pending;
  logic [4:0]  wb_pending_rd;
  logic        err;

  modport master (
    output in_valid, in_rd, in_wb_sel, in_alu_result, in_pc_plus4, in_funct3, in_addr_lsb,
    output mem_rvalid, mem_rdata,
    input  in_ready, w_en, rd, w_data, wb_pending, wb_pending_rd, err
  );

  modport slave (
    input  in_valid, in_rd, in_wb_sel, in_alu_result, in_pc_plus4, in_funct3, in_addr_lsb,
    input  mem_rvalid, mem_rdata,
    output in_ready, w_en, rd, w_data, wb_pending, wb_pending_rd, err
  );
endinterface

// File: rtl/writeback_unit.sv
// RV32I write-back stage: selects ALU / PC+4 / formatted load data and drives the
// register-file write port from registers, with a bounded wait for load data.
module writeback_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              reset,
  writeback_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

  localparam int unsigned TimeoutClamped = TIMEOUT_CYCLES & 32'hFF;
  localparam logic [7:0]  TimeoutLimit   = TimeoutClamped[7:0];

  state_e      state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lsb_q, lsb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic [31:0] out_data_q, out_data_d;

  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Byte chosen by both address bits, halfword by bit 1 only; misalignment passes through.
  always_comb begin
    case (lsb_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lsb_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  assign bus.in_ready = (state_q != StWaitMem);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    lsb_d      = lsb_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StIdle, StWrite: begin
        state_d = StIdle;
        if (accept) begin
          rd_d     = bus.in_rd;
          funct3_d = bus.in_funct3;
          lsb_d    = bus.in_addr_lsb;
          unique case (bus.in_wb_sel)
            2'b01: begin
              state_d    = StWrite;
              out_rd_d   = bus.in_rd;
              out_data_d = bus.in_alu_result;
            end
            2'b11: begin
              state_d    = StWrite;
              out_rd_d   = bus.in_rd;
              out_data_d = bus.in_pc_plus4;
            end
            2'b10: begin
              state_d = StWaitMem;
              cnt_d   = 8'd0;
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StWaitMem: begin
        // Data arriving on the timeout edge still wins.
        if (bus.mem_rvalid) begin
          state_d    = StWrite;
          out_rd_d   = rd_q;
          out_data_d = ld_data;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TimeoutLimit) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rd_q       <= 5'd0;
      funct3_q   <= 3'd0;
      lsb_q      <= 2'd0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      out_rd_q   <= 5'd0;
      out_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      lsb_q      <= lsb_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.w_en          = (state_q == StWrite) && (rd_q != 5'd0);
  assign bus.rd            = out_rd_q;
  assign bus.w_data        = out_data_q;
  assign bus.wb_pending    = ((state_q == StWaitMem) || (state_q == StWrite)) && (rd_q != 5'd0);
  assign bus.wb_pending_rd = rd_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are queued at issue time and
// a negedge monitor pops and compares every register-file write.
module tb_writeback_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if bus ();

  writeback_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write at %0t",
                 bus.rd, bus.w_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, bus.rd}, {27'd0, e.rd});
        chk("wb_data", bus.w_data, e.data);
      end
    end
    if (bus.err === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; it is accepted on the next edge (in_ready checked first).
  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [2:0] f3, input logic [1:0] lsb);
    chk("in_ready_at_issue", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid      = 1'b1;
    bus.in_rd         = rd;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_pc_plus4   = pc4;
    bus.in_funct3     = f3;
    bus.in_addr_lsb   = lsb;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lsb,
                      input logic [31:0] word, input int wait_n, input bit rv_at_accept,
                      input logic [31:0] exp);
    if (rd != 5'd0) exp_q.push_back('{rd: rd, data: exp});
    bus.mem_rvalid = rv_at_accept;
    bus.mem_rdata  = 32'hA5A5_A5A5;
    issue(rd, 2'b10, 32'h0, 32'h0, f3, lsb);
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    chk("pending_wait", {31'd0, bus.wb_pending}, {31'd0, (rd != 5'd0)});
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = word;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("load_w_en", {31'd0, bus.w_en}, {31'd0, (rd != 5'd0)});
    chk("load_w_data", bus.w_data, exp);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_w_en"}, {31'd0, bus.w_en}, 32'd0);
    chk({tag, "_rd"}, {27'd0, bus.rd}, 32'd0);
    chk({tag, "_w_data"}, bus.w_data, 32'd0);
    chk({tag, "_pending"}, {31'd0, bus.wb_pending}, 32'd0);
    chk({tag, "_pending_rd"}, {27'd0, bus.wb_pending_rd}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_rd         = 5'd0;
    bus.in_wb_sel     = 2'b00;
    bus.in_alu_result = 32'd0;
    bus.in_pc_plus4   = 32'd0;
    bus.in_funct3     = 3'd0;
    bus.in_addr_lsb   = 2'd0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Single ALU op: write visible for exactly one cycle.
    exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
    issue(5'd5, 2'b01, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0);
    chk("alu_w_en", {31'd0, bus.w_en}, 32'd1);
    chk("alu_rd", {27'd0, bus.rd}, 32'd5);
    chk("alu_w_data", bus.w_data, 32'hDEAD_BEEF);
    chk("alu_pending", {31'd0, bus.wb_pending}, 32'd1);
    chk("alu_pending_rd", {27'd0, bus.wb_pending_rd}, 32'd5);
    tick();
    chk("alu_w_en_drop", {31'd0, bus.w_en}, 32'd0);
    chk("alu_pending_drop", {31'd0, bus.wb_pending}, 32'd0);
    chk("alu_rd_hold", {27'd0, bus.rd}, 32'd5);

    // Back-to-back ALU ops plus a PC+4 link.
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back('{rd: 5'(i), data: 32'h1000_0000 + 32'(i)});
      issue(5'(i), 2'b01, 32'h1000_0000 + 32'(i), 32'h0, 3'd0, 2'd0);
      chk("b2b_w_en", {31'd0, bus.w_en}, 32'd1);
    end
    exp_q.push_back('{rd: 5'd31, data: 32'h0000_1004});
    issue(5'd31, 2'b11, 32'hFFFF_FFFF, 32'h0000_1004, 3'd0, 2'd0);
    chk("link_w_data", bus.w_data, 32'h0000_1004);
    tick();

    // Loads; LB waits 3 edges so data lands on the timeout edge and must win.
    load(5'd10, 3'b000, 2'd2, 32'h12F4_5678, 3, 1'b0, 32'hFFFF_FFF4);
    load(5'd11, 3'b100, 2'd2, 32'h12F4_5678, 2, 1'b1, 32'h0000_00F4);
    load(5'd12, 3'b001, 2'd2, 32'h12F4_5678, 0, 1'b0, 32'h0000_12F4);
    load(5'd13, 3'b001, 2'd0, 32'h1234_ABCD, 1, 1'b0, 32'hFFFF_ABCD);
    load(5'd14, 3'b101, 2'd0, 32'h1234_ABCD, 1, 1'b0, 32'h0000_ABCD);
    load(5'd15, 3'b000, 2'd1, 32'h1234_ABCD, 1, 1'b0, 32'hFFFF_FFAB);
    load(5'd16, 3'b100, 2'd3, 32'h1234_ABCD, 1, 1'b0, 32'h0000_0012);
    load(5'd17, 3'b010, 2'd0, 32'h1234_ABCD, 1, 1'b0, 32'h1234_ABCD);
    load(5'd18, 3'b111, 2'd1, 32'h8765_4321, 1, 1'b0, 32'h8765_4321);

    // Timeout: no response for 4 WAIT_MEM edges.
    issue(5'd7, 2'b10, 32'h0, 32'h0, 3'b010, 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk("to_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("to_err_low", {31'd0, bus.err}, 32'd0);
      tick();
    end
    chk("to_pending", {31'd0, bus.wb_pending}, 32'd1);
    tick();
    chk("to_err_pulse", {31'd0, bus.err}, 32'd1);
    chk("to_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    chk("to_pending_clear", {31'd0, bus.wb_pending}, 32'd0);
    tick();
    chk("to_err_one_cycle", {31'd0, bus.err}, 32'd0);

    // rd = 0 and wb_sel 00: no write at all.
    issue(5'd0, 2'b01, 32'h5555_5555, 32'h0, 3'd0, 2'd0);
    chk("x0_w_en", {31'd0, bus.w_en}, 32'd0);
    chk("x0_pending", {31'd0, bus.wb_pending}, 32'd0);
    issue(5'd4, 2'b00, 32'h6666_6666, 32'h0, 3'd0, 2'd0);
    chk("none_w_en", {31'd0, bus.w_en}, 32'd0);
    chk("none_pending", {31'd0, bus.wb_pending}, 32'd0);
    chk("none_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("none_rd_hold", {27'd0, bus.rd}, 32'd0);
    tick();

    // Reset while waiting on a load, then a late response.
    issue(5'd9, 2'b10, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("rst_wait");
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    tick();
    tick();
    bus.mem_rvalid = 1'b0;
    check_reset_outputs("late_rvalid");
    tick();

    chk("err_pulse_count", 32'(err_seen), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage of the RV32I core, directly upstream of the register file. Accepts completed instructions from the memory stage over a valid/ready handshake. Waits for load data when required, then aligns and sign- or zero-extends it. Drives the register-file write port (`w_en`, `rd`, `w_data`) with registered outputs, and exposes the pending destination register to hazard logic.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum number of cycles spent in WAIT_MEM before a load is abandoned (range 1..255).

Ports:
- `clk` in 1: single clock. All state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: upstream has an instruction.
- `in_ready` out 1: this block accepts an instruction this cycle.
- `in_rd` in 5: destination register.
- `in_wb_sel` in 2: write-back source. 00 none, 01 ALU, 10 load, 11 PC+4.
- `in_alu_result` in 32: ALU result.
- `in_pc_plus4` in 32: link value.
- `in_funct3` in 3: load type.
- `in_addr_lsb` in 2: load address bits [1:0].
- `mem_rvalid` in 1: load data valid.
- `mem_rdata` in 32: raw word from data memory.
- `w_en` out 1: register-file write enable.
- `rd` out 5: register-file write address.
- `w_data` out 32: register-file write data.
- `wb_pending` out 1: a write to a nonzero register is in flight.
- `wb_pending_rd` out 5: destination of the in-flight write.
- `err` out 1: one-cycle pulse on load timeout.

## Operation
- FSM states: IDLE, WAIT_MEM, WRITE.
- `in_ready` = 1 in IDLE and WRITE; 0 in WAIT_MEM.
- Acceptance occurs when `in_valid & in_ready`. On acceptance, latch `in_rd`, `funct3` and `addr_lsb`, then branch on `in_wb_sel`:
  - wb_sel 01: go to WRITE with data = `in_alu_result`.
  - wb_sel 11: go to WRITE with data = `in_pc_plus4`.
  - wb_sel 10: go to WAIT_MEM and clear the timeout counter.
  - wb_sel 00: go to IDLE; no write occurs.
- WRITE with no acceptance: go to IDLE.
- WAIT_MEM:
  - `mem_rvalid` = 1: latch the formatted data and go to WRITE.
  - Otherwise: increment the counter. When the counter reaches `TIMEOUT_CYCLES`, pulse `err` for one cycle, go to IDLE and perform no write.
- `mem_rvalid` is ignored outside WAIT_MEM, including in the acceptance cycle of the load.
- Load formatting selects a byte with `addr_lsb` and a halfword with `addr_lsb[1]`:
  - 000 LB: sign-extend the selected byte.
  - 100 LBU: zero-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 101 LHU: zero-extend the selected halfword.
  - 010 LW: full word.
  - 011, 110, 111: treated as LW.
  - Misalignment is not detected.
- `w_en` = 1 only in WRITE with latched rd ≠ 0. For rd = 0 the state sequence is identical but `w_en` stays 0.
- `rd` and `w_data` hold their last values outside WRITE.
- `wb_pending` = (state is WAIT_MEM or WRITE) and latched rd ≠ 0. `wb_pending_rd` = latched rd.

## Timing
- Reset: state IDLE; `w_en`, `err`, `wb_pending` = 0; `rd`, `wb_pending_rd` = 0; `w_data` = 0; counter = 0.
- Reset in WAIT_MEM drops the load. A late `mem_rvalid` is ignored.
- ALU and PC+4 latency: accepted at edge t, then `w_en` is high for the full cycle after edge t. The register file captures the value on the falling edge inside that cycle.
- Throughput: one ALU or PC+4 instruction per cycle, back-to-back. Acceptance during WRITE chains directly to the next WRITE or to WAIT_MEM.
- Load latency: `mem_rvalid` sampled at edge t, then `w_en` is high in the cycle after edge t.
- Earliest `mem_rvalid` sample is the first edge after the acceptance edge.
- Timeout: with no response, `err` pulses in the cycle after the `TIMEOUT_CYCLES`-th WAIT_MEM edge, and the state is IDLE in that same cycle.
- If `mem_rvalid` and the timeout coincide, the data wins: go to WRITE, no `err`.

## Test plan
- Reset, then ALU op (rd = 5, result 0xDEADBEEF) → `w_en` = 1 for one cycle, `rd` = 5, `w_data` = 0xDEADBEEF, `wb_pending` = 1 in that cycle.
- Three back-to-back ALU ops (rd = 1, 2, 3) with `in_valid` held high → `in_ready` stays 1 and `w_en` is high for three consecutive cycles in order.
- LB with `addr_lsb` = 2 and `mem_rdata` = 0x12F45678 after a 3-cycle wait → `in_ready` = 0 for the wait, `w_data` = 0xFFFFFFF4. LBU gives 0x000000F4. LH with lsb = 2 gives 0x000012F4.
- Load with no response and `TIMEOUT_CYCLES` = 4 → `err` pulses once, no `w_en`, `in_ready` returns to 1.
- ALU op to rd = 0 → no `w_en`, `wb_pending` = 0. wb_sel 00 → no write.
- Reset asserted during WAIT_MEM, then `mem_rvalid` → no write, state IDLE, all outputs at reset values.
